ysyx_22040895_ifu_fq: RTL

Parametrised instruction-fetch unit with a decoupled memory interface and an in-order fetch queue. It generates sequential PCs and issues up to DEPTH pipelined requests to instruction memory. Responses are paired with their PCs, and fetched instructions are handed to decode over a valid/ready port. Redirects from the EXU/branch logic flush queued and in-flight fetches. It replaces the combinational pass-through fetch stage between the PC/imem and the IDU.

---
 rtl/ysyx_22040895_ifu_fq.sv | 128 ++++++++++++
 1 files changed

// File: rtl/ysyx_22040895_ifu_fq.sv
// Instruction-fetch unit with a decoupled imem port and an in-order fetch queue.
// Entries are reserved at issue and filled in order as responses return.
module ysyx_22040895_ifu_fq #(
  parameter int          XLEN     = 64,
  parameter int          ILEN     = 32,
  parameter logic [63:0] RESET_PC = 64'h8000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic            clk,
  input  logic            rst,
  output logic            req_valid,
  input  logic            req_ready,
  output logic [XLEN-1:0] req_addr,
  input  logic            resp_valid,
  input  logic [ILEN-1:0] resp_data,
  input  logic            resp_err,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [ILEN-1:0] out_inst,
  output logic [XLEN-1:0] out_pc,
  output logic            out_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [XLEN-1:0] RPC = RESET_PC[XLEN-1:0];

  typedef logic [AW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  logic            run;
  logic [XLEN-1:0] fetch_pc;
  ptr_t            head;
  ptr_t            tail;
  ptr_t            fptr;
  cnt_t            count;
  cnt_t            pend;
  cnt_t            drop;
  cnt_t            owed;

  logic [XLEN-1:0] pc_q   [DEPTH];
  logic [ILEN-1:0] inst_q [DEPTH];
  logic [DEPTH-1:0] err_q;
  logic [DEPTH-1:0] fill_q;

  logic issue;
  logic pop;
  logic take;
  logic disc;

  assign req_valid = run & ~redirect_valid
                   & (count < cnt_t'(DEPTH));
  assign req_addr  = fetch_pc;
  assign issue     = req_valid & req_ready;

  assign out_valid = fill_q[head] & (count != '0)
                   & ~redirect_valid;
  assign pop       = out_valid & out_ready;
  assign out_inst  = inst_q[head];
  assign out_pc    = pc_q[head];
  assign out_err   = err_q[head];

  // Responses owed to a flushed path are swallowed before any fill.
  assign take = resp_valid & (drop == '0) & (pend != '0);
  assign disc = resp_valid & (drop != '0);
  assign owed = pend + drop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run      <= 1'b0;
      fetch_pc <= RPC;
      head     <= '0;
      tail     <= '0;
      fptr     <= '0;
      count    <= '0;
      pend     <= '0;
      drop     <= '0;
      err_q    <= '0;
      fill_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]   <= '0;
        inst_q[i] <= '0;
      end
    end else begin
      run <= 1'b1;
      if (redirect_valid) begin
        fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
        head     <= '0;
        tail     <= '0;
        fptr     <= '0;
        count    <= '0;
        pend     <= '0;
        drop     <= owed - cnt_t'(resp_valid && owed != '0);
        err_q    <= '0;
        fill_q   <= '0;
        for (int i = 0; i < DEPTH; i++) begin
          pc_q[i]   <= '0;
          inst_q[i] <= '0;
        end
      end else begin
        if (issue) begin
          pc_q[tail]   <= fetch_pc;
          fill_q[tail] <= 1'b0;
          tail         <= tail + ptr_t'(1);
          fetch_pc     <= fetch_pc + XLEN'(4);
        end
        if (take) begin
          inst_q[fptr] <= resp_data;
          err_q[fptr]  <= resp_err;
          fill_q[fptr] <= 1'b1;
          fptr         <= fptr + ptr_t'(1);
        end
        if (disc) begin
          drop <= drop - cnt_t'(1);
        end
        if (pop) begin
          fill_q[head] <= 1'b0;
          head         <= head + ptr_t'(1);
        end
        count <= count + cnt_t'(issue) - cnt_t'(pop);
        pend  <= pend + cnt_t'(issue) - cnt_t'(take);
      end
    end
  end

endmodule
